// File: rtl/uart_apb_controller_if.sv
// APB bus bundle between the UART controller (master) and the UART register slave.
interface uart_apb_controller_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pslverr
  );
endinterface

// File: rtl/uart_apb_controller.sv
// APB master that programs the UART receiver slave and streams received
// characters to a downstream consumer over a valid/ready handshake.
module uart_apb_controller #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [13:0] cfg_bit_period,
  input  logic [3:0]  cfg_data_size,
  input  logic        run,
  output logic        cfg_done,
  output logic        busy,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic [1:0]  rx_err,
  output logic        slv_err,
  uart_apb_controller_if.master apb
);

  localparam int unsigned GAP_W    = 8;
  localparam bit          GAP_NONE = (POLL_GAP == 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_NONE ? '0 : GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_HOLD} state_e;
  typedef enum logic [2:0] {OP_W_BPL, OP_W_BPH, OP_W_DSZ, OP_R_STAT, OP_R_ERR, OP_R_DAT} op_e;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } txn_t;

  state_e           r_state;
  op_e              r_op;
  txn_t             r_txn;
  logic             r_psel;
  logic             r_penable;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [13:0]      r_bit_period;
  logic [3:0]       r_data_size;

  // Address, direction and write data of the slave access selected by op.
  function automatic txn_t txn_of(input op_e op, input logic [13:0] bp, input logic [3:0] ds);
    txn_t t;
    t = '0;
    case (op)
      OP_W_BPL:  begin t.write = 1'b1; t.addr = 3'd2; t.wdata = bp[7:0];          end
      OP_W_BPH:  begin t.write = 1'b1; t.addr = 3'd3; t.wdata = {2'b00, bp[13:8]}; end
      OP_W_DSZ:  begin t.write = 1'b1; t.addr = 3'd4; t.wdata = {4'b0000, ds};     end
      OP_R_STAT: t.addr = 3'd0;
      OP_R_ERR:  t.addr = 3'd1;
      OP_R_DAT:  t.addr = 3'd6;
      default:   t = '0;
    endcase
    return t;
  endfunction

  assign apb.psel    = r_psel;
  assign apb.penable = r_penable;
  assign apb.pwrite  = r_txn.write;
  assign apb.paddr   = r_txn.addr;
  assign apb.pwdata  = r_txn.wdata;

  // Controller FSM: sequences APB transactions; all bus and status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_W_BPL;
      r_txn        <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_gap_cnt    <= '0;
      r_bit_period <= '0;
      r_data_size  <= '0;
      cfg_done     <= 1'b0;
      busy         <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_err       <= '0;
      slv_err      <= 1'b0;
    end else begin
      // Bus idles at zero unless a SETUP/ACCESS phase is entered below.
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_txn     <= '0;
      cfg_done  <= 1'b0;
      busy      <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_bit_period <= cfg_bit_period;
            r_data_size  <= cfg_data_size;
            r_op         <= OP_W_BPL;
            r_txn        <= txn_of(OP_W_BPL, cfg_bit_period, cfg_data_size);
            r_psel       <= 1'b1;
            r_state      <= S_SETUP;
          end else if (run) begin
            r_op    <= OP_R_STAT;
            r_txn   <= txn_of(OP_R_STAT, r_bit_period, r_data_size);
            r_psel  <= 1'b1;
            r_state <= S_SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        S_SETUP: begin
          r_psel    <= 1'b1;
          r_penable <= 1'b1;
          r_txn     <= r_txn;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb.pslverr) begin
            slv_err <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            case (r_op)
              OP_W_BPL: begin
                r_op    <= OP_W_BPH;
                r_txn   <= txn_of(OP_W_BPH, r_bit_period, r_data_size);
                r_psel  <= 1'b1;
                r_state <= S_SETUP;
              end
              OP_W_BPH: begin
                r_op    <= OP_W_DSZ;
                r_txn   <= txn_of(OP_W_DSZ, r_bit_period, r_data_size);
                r_psel  <= 1'b1;
                r_state <= S_SETUP;
              end
              OP_W_DSZ: begin
                cfg_done <= 1'b1;
                busy     <= 1'b0;
                r_state  <= S_IDLE;
              end
              OP_R_STAT: begin
                if (apb.prdata[0]) begin
                  r_op    <= OP_R_ERR;
                  r_txn   <= txn_of(OP_R_ERR, r_bit_period, r_data_size);
                  r_psel  <= 1'b1;
                  r_state <= S_SETUP;
                end else if (!GAP_NONE) begin
                  r_gap_cnt <= GAP_LOAD;
                  r_state   <= S_GAP;
                end else if (run) begin
                  r_op    <= OP_R_STAT;
                  r_txn   <= txn_of(OP_R_STAT, r_bit_period, r_data_size);
                  r_psel  <= 1'b1;
                  r_state <= S_SETUP;
                end else begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
                end
              end
              OP_R_ERR: begin
                rx_err  <= apb.prdata[1:0];
                r_op    <= OP_R_DAT;
                r_txn   <= txn_of(OP_R_DAT, r_bit_period, r_data_size);
                r_psel  <= 1'b1;
                r_state <= S_SETUP;
              end
              OP_R_DAT: begin
                rx_data  <= apb.prdata;
                rx_valid <= 1'b1;
                r_state  <= S_HOLD;
              end
              default: begin
                busy    <= 1'b0;
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            if (run) begin
              r_op    <= OP_R_STAT;
              r_txn   <= txn_of(OP_R_STAT, r_bit_period, r_data_size);
              r_psel  <= 1'b1;
              r_state <= S_SETUP;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        S_HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            if (!run) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else if (!GAP_NONE) begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= S_GAP;
            end else begin
              r_op    <= OP_R_STAT;
              r_txn   <= txn_of(OP_R_STAT, r_bit_period, r_data_size);
              r_psel  <= 1'b1;
              r_state <= S_SETUP;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_controller.sv
// Directed bench for uart_apb_controller with a small behavioural APB slave.
module tb_uart_apb_controller;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [13:0] cfg_bit_period;
  logic [3:0]  cfg_data_size;
  logic        run;
  logic        cfg_done;
  logic        busy;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic [1:0]  rx_err;
  logic        slv_err;

  uart_apb_controller_if apb_if ();

  uart_apb_controller #(.POLL_GAP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_bit_period (cfg_bit_period),
    .cfg_data_size  (cfg_data_size),
    .run            (run),
    .cfg_done       (cfg_done),
    .busy           (busy),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_err         (rx_err),
    .slv_err        (slv_err),
    .apb            (apb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave registers, driven by the stimulus process only.
  logic       sl_stat;
  logic [1:0] sl_err;
  logic [7:0] sl_data;
  logic       err_en;
  logic [2:0] err_addr;

  // Slave read mux and error injection.
  always_comb begin
    case (apb_if.paddr)
      3'd0:    apb_if.prdata = {7'b0, sl_stat};
      3'd1:    apb_if.prdata = {6'b0, sl_err};
      3'd6:    apb_if.prdata = sl_data;
      default: apb_if.prdata = 8'h00;
    endcase
    apb_if.pslverr = err_en && apb_if.psel && apb_if.penable && (apb_if.paddr == err_addr);
  end

  // Bus monitor: logs completed accesses and R_STAT setup cycles.
  int          cyc = 0;
  logic [10:0] wr_q[$];
  logic [2:0]  rd_addr_q[$];
  int          rd_cyc_q[$];
  int          stat_q[$];
  int          valid_cnt = 0;

  always @(posedge clk) begin
    if (apb_if.psel && apb_if.penable) begin
      if (apb_if.pwrite) wr_q.push_back({apb_if.paddr, apb_if.pwdata});
      else begin
        rd_addr_q.push_back(apb_if.paddr);
        rd_cyc_q.push_back(cyc);
      end
    end
    if (apb_if.psel && !apb_if.penable && !apb_if.pwrite && apb_if.paddr == 3'd0)
      stat_q.push_back(cyc);
    if (rx_valid) valid_cnt = valid_cnt + 1;
    cyc = cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    while (busy && k < max) begin
      tick(1);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int max, output int seen_cyc);
    int k;
    k = 0;
    while (!rx_valid && k < max) begin
      tick(1);
      k++;
    end
    seen_cyc = cyc;
    check(tag, 32'(rx_valid), 32'd1);
  endtask

  int busy_cnt, done_cnt, done_at, base, vbase, seen, rbase, apb_busy, unstable;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_bit_period = '0; cfg_data_size = '0;
    run = 1'b0; rx_ready = 1'b0;
    sl_stat = 1'b0; sl_err = 2'd0; sl_data = 8'h00; err_en = 1'b0; err_addr = 3'd4;

    // Reset values
    tick(2);
    check("rst_psel",     32'(apb_if.psel),    32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_rx_valid", 32'(rx_valid),       32'd0);
    check("rst_rx_data",  32'(rx_data),        32'h00);
    check("rst_slv_err",  32'(slv_err),        32'd0);
    check("rst_cfg_done", 32'(cfg_done),       32'd0);
    rst = 1'b0;
    tick(2);

    // Configuration write sequence and timing
    base = wr_q.size();
    cfg_start = 1'b1; cfg_bit_period = 14'h1A2B; cfg_data_size = 4'd8;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      if (c == 1) begin
        cfg_start = 1'b0;
        check("cfg_setup_psel",    32'(apb_if.psel),    32'd1);
        check("cfg_setup_penable", 32'(apb_if.penable), 32'd0);
        check("cfg_setup_paddr",   32'(apb_if.paddr),   32'd2);
        check("cfg_setup_pwdata",  32'(apb_if.pwdata),  32'h2B);
      end
      if (c == 2) check("cfg_access_penable", 32'(apb_if.penable), 32'd1);
      if (busy) busy_cnt++;
      if (cfg_done) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
    end
    check("cfg_done_at",   32'(done_at),  32'd7);
    check("cfg_done_cnt",  32'(done_cnt), 32'd1);
    check("cfg_busy_cnt",  32'(busy_cnt), 32'd6);
    check("cfg_nwrites",   32'(wr_q.size() - base), 32'd3);
    if (wr_q.size() - base == 3) begin
      check("cfg_wr0", 32'(wr_q[base]),   32'({3'd2, 8'h2B}));
      check("cfg_wr1", 32'(wr_q[base+1]), 32'({3'd3, 8'h1A}));
      check("cfg_wr2", 32'(wr_q[base+2]), 32'({3'd4, 8'h08}));
    end

    // Empty polling: R_STAT setups every 2+POLL_GAP cycles, no characters
    base = stat_q.size(); vbase = valid_cnt;
    run = 1'b1;
    tick(30);
    run = 1'b0;
    wait_idle("poll_stop", 20);
    check("poll_count_ge4", 32'(stat_q.size() - base >= 4), 32'd1);
    if (stat_q.size() - base >= 4) begin
      for (int i = 1; i < 4; i++)
        check("poll_period", 32'(stat_q[base+i] - stat_q[base+i-1]), 32'd6);
    end
    check("poll_no_valid", 32'(valid_cnt - vbase), 32'd0);

    // Character fetch, no error
    rbase = rd_addr_q.size();
    sl_stat = 1'b1; sl_err = 2'd0; sl_data = 8'hA5;
    run = 1'b1;
    wait_valid("fetch0_valid", 40, seen);
    sl_stat = 1'b0;
    check("fetch0_data", 32'(rx_data), 32'hA5);
    check("fetch0_err",  32'(rx_err),  32'd0);
    check("fetch0_nreads", 32'(rd_addr_q.size() - rbase >= 3), 32'd1);
    if (rd_addr_q.size() - rbase >= 3) begin
      base = rd_addr_q.size() - 3;
      check("fetch0_addr0", 32'(rd_addr_q[base]),   32'd0);
      check("fetch0_addr1", 32'(rd_addr_q[base+1]), 32'd1);
      check("fetch0_addr2", 32'(rd_addr_q[base+2]), 32'd6);
      check("fetch0_b2b",   32'(rd_cyc_q[base+2] - rd_cyc_q[base]), 32'd4);
      check("fetch0_valid_lat", 32'(seen - rd_cyc_q[base+2]), 32'd1);
    end

    // Backpressure: word held stable with a silent bus
    apb_busy = 0; unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (apb_if.psel) apb_busy++;
      if (!rx_valid || rx_data != 8'hA5 || rx_err != 2'd0) unstable++;
    end
    check("bp_apb_quiet", 32'(apb_busy), 32'd0);
    check("bp_stable",    32'(unstable), 32'd0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("bp_valid_drop", 32'(rx_valid),    32'd0);
    check("bp_gap_busy",   32'(busy),        32'd1);
    check("bp_gap_psel",   32'(apb_if.psel), 32'd0);

    // Character fetch with overrun error
    sl_stat = 1'b1; sl_err = 2'd2; sl_data = 8'h3C;
    wait_valid("fetch1_valid", 40, seen);
    sl_stat = 1'b0;
    check("fetch1_data", 32'(rx_data), 32'h3C);
    check("fetch1_err",  32'(rx_err),  32'd2);
    run = 1'b0; rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("fetch1_drop", 32'(rx_valid), 32'd0);
    wait_idle("fetch1_idle", 20);

    // Slave error on data size write
    err_en = 1'b1; err_addr = 3'd4;
    cfg_start = 1'b1; cfg_bit_period = 14'h0123; cfg_data_size = 4'd5;
    done_cnt = 0;
    tick(1);
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cfg_done) done_cnt++;
    end
    check("serr_sticky",  32'(slv_err),  32'd1);
    check("serr_no_done", 32'(done_cnt), 32'd0);
    check("serr_idle",    32'(busy),     32'd0);
    err_en = 1'b0;
    base = wr_q.size();
    cfg_start = 1'b1;
    done_cnt = 0;
    tick(1);
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cfg_done) done_cnt++;
    end
    check("serr_retry_done", 32'(done_cnt), 32'd1);
    check("serr_still_set",  32'(slv_err),  32'd1);
    check("serr_retry_nwr",  32'(wr_q.size() - base), 32'd3);
    if (wr_q.size() - base == 3) begin
      check("serr_wr0", 32'(wr_q[base]),   32'({3'd2, 8'h23}));
      check("serr_wr1", 32'(wr_q[base+1]), 32'({3'd3, 8'h01}));
      check("serr_wr2", 32'(wr_q[base+2]), 32'({3'd4, 8'h05}));
    end

    // Reset during the R_ERR access
    sl_stat = 1'b1; sl_err = 2'd1; sl_data = 8'h77;
    run = 1'b1;
    begin
      int k;
      k = 0;
      while (!(apb_if.psel && apb_if.penable && apb_if.paddr == 3'd1) && k < 40) begin
        tick(1);
        k++;
      end
      check("rerr_reached", 32'(apb_if.psel && apb_if.penable && apb_if.paddr == 3'd1), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("mrst_psel",     32'(apb_if.psel),    32'd0);
    check("mrst_penable",  32'(apb_if.penable), 32'd0);
    check("mrst_paddr",    32'(apb_if.paddr),   32'd0);
    check("mrst_busy",     32'(busy),           32'd0);
    check("mrst_rx_data",  32'(rx_data),        32'h00);
    check("mrst_rx_err",   32'(rx_err),         32'd0);
    check("mrst_slv_err",  32'(slv_err),        32'd0);
    sl_stat = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("resume_psel",    32'(apb_if.psel),    32'd1);
    check("resume_penable", 32'(apb_if.penable), 32'd0);
    check("resume_paddr",   32'(apb_if.paddr),   32'd0);
    check("resume_pwrite",  32'(apb_if.pwrite),  32'd0);
    run = 1'b0;
    wait_idle("final_idle", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_controller.md
# uart_apb_controller

APB master that configures and services the UART receiver's APB register slave. On `cfg_start` it programs bit period and data size. While `run` is high it polls the receive status, fetches error status and data on each new character, and delivers each character to a downstream consumer over a valid/ready handshake. It sits between the system control logic and the UART APB slave, which is its only bus peer. It replaces hand-driven bus sequences in the top level.

## Interface
Parameters:
- `POLL_GAP`, default 4: idle cycles between consecutive status polls when no data is pending; legal range 0–255.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_start` in 1: single-cycle request to (re)program the slave. Accepted only in IDLE.
- `cfg_bit_period` in 14: bit period value; sampled when `cfg_start` is accepted.
- `cfg_data_size` in 4: data size, 5/7/8; sampled when `cfg_start` is accepted.
- `run` in 1: enables status polling.
- `cfg_done` out 1: one-cycle pulse after the third configuration write completes.
- `busy` out 1: high in every state except IDLE.
- `rx_valid` out 1: `rx_data` and `rx_err` are valid.
- `rx_ready` in 1: consumer accepts the word on `rx_valid && rx_ready`.
- `rx_data` out 8: received character as returned by the slave.
- `rx_err` out 2: error code captured with the character: 0 none, 1 framing, 2 overrun.
- `slv_err` out 1: sticky; set by any `pslverr` seen in ACCESS. Cleared only by `rst`.
- `psel`, `penable`, `pwrite` out 1 each: APB controls.
- `paddr` out 3: APB address.
- `pwdata` out 8: APB write data.
- `prdata` in 8: APB read data.
- `pslverr` in 1: APB slave error.

## Operation
Slave register map used:
- 0: status; bit0 = data ready.
- 1: error code.
- 2: bit period [7:0].
- 3: bit period [13:8], upper bits of the byte are 0.
- 4: data size.
- 6: rx data; reading it clears ready.

Other addresses are never driven.

State machine: IDLE, SETUP, ACCESS, GAP, HOLD. A 3-bit `op` register selects the transaction: W_BPL, W_BPH, W_DSZ, R_STAT, R_ERR, R_DAT.

- **IDLE**
  - `cfg_start` takes priority: latch config, set `op`=W_BPL, go to SETUP.
  - Otherwise, if `run` is high: set `op`=R_STAT, go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP**
  - Drive `psel`=1, `penable`=0, and `paddr`/`pwrite`/`pwdata` per `op`.
  - Always go to ACCESS next cycle.
- **ACCESS**
  - Same outputs with `penable`=1. Sample `prdata` and `pslverr` this cycle.
  - `pslverr`=1: set `slv_err`, abandon the sequence, go to IDLE.
  - W_BPL → W_BPH → W_DSZ, each via SETUP.
  - After W_DSZ: pulse `cfg_done`, go to IDLE.
  - R_STAT with bit0=0: go to GAP.
  - R_STAT with bit0=1: go to R_ERR via SETUP.
  - R_ERR: latch `prdata[1:0]` into `rx_err`, go to R_DAT via SETUP.
  - R_DAT: latch `prdata` into `rx_data`, go to HOLD.
- **GAP**
  - Counter counts `POLL_GAP` cycles; with `POLL_GAP`=0 GAP lasts zero cycles.
  - When the count expires: go to R_STAT/SETUP if `run` is high, else IDLE.
  - `cfg_start` is ignored here.
- **HOLD**
  - `rx_valid`=1, polling stalled.
  - On `rx_ready`: go to GAP if `run` is high, else IDLE.
- Outside SETUP/ACCESS, all APB outputs are 0.
- Once a transaction has started it always completes; `run` falling mid-sequence finishes the current character before stopping.

## Timing
- Reset values:
  - State IDLE; `psel`, `penable`, `pwrite`, `paddr`, `pwdata` = 0.
  - `cfg_done`, `busy`, `rx_valid`, `slv_err` = 0; `rx_data`=0x00, `rx_err`=0.
  - GAP counter = 0.
- Each APB transaction takes exactly 2 cycles; transactions run back to back with no idle cycle between them.
- Configuration: `cfg_start` seen at edge N. SETUP of W_BPL occupies cycle N+1. `cfg_done` is high in cycle N+7. `busy` is high during cycles N+1..N+6.
- Empty poll period: 2 + `POLL_GAP` cycles between successive R_STAT SETUP cycles.
- Character fetch: 6 cycles from R_STAT SETUP to the last ACCESS. `rx_valid` rises the cycle after the R_DAT ACCESS.
- `rx_valid` holds, with `rx_data`/`rx_err` stable, until the `rx_ready` handshake. It drops the cycle after the handshake.
- `rst` asserted mid-transaction: every output returns to its reset value asynchronously, including deasserting `psel` immediately. No partial configuration is retried.

## Test plan
- **Configuration write:** `cfg_start` with `cfg_bit_period`=0x1A2B, `cfg_data_size`=8 → three writes: (addr 2, 0x2B), (addr 3, 0x1A), (addr 4, 0x08), each `psel` then `penable`. `cfg_done` pulses 7 cycles after start; `busy` high for 6 cycles.
- **Empty polling:** `run`=1, slave status 0, `POLL_GAP`=4 → reads of addr 0 start every 6 cycles; `rx_valid` never rises.
- **Character fetch:** status 0x01, error 0, data 0xA5 → reads of addr 0, then 1, then 6, back to back. `rx_valid`=1 with `rx_data`=0xA5, `rx_err`=0. Repeat with error 2 → `rx_err`=2.
- **Backpressure:** hold `rx_ready`=0 for 10 cycles → `rx_valid` and the data stay stable with no APB activity. Raise `rx_ready` → one handshake, `rx_valid` low the next cycle, then GAP.
- **Slave error:** slave returns `pslverr` on the addr 4 write → `slv_err` sticks at 1, no `cfg_done`, FSM returns to IDLE. A subsequent `cfg_start` still runs.
- **Reset mid-transaction:** assert `rst` during an ACCESS of R_ERR → `psel`/`penable` drop immediately and all outputs take their reset values. After `rst` deasserts, polling resumes from R_STAT if `run`=1.
